// File: rtl/fifo_pkg.sv
// ============================================================================
// fifo_pkg : shared state encoding and defaults for the sync_fifo read side
// Rev 1.0
// ============================================================================
`default_nettype none

package fifo_pkg;

    localparam int SKID_DEPTH        = 2;
    localparam int DEF_DATA_WIDTH    = 8;
    localparam int DEF_TIMEOUT_LIMIT = 128;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_FIN   = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/skid_buf2.sv
// ============================================================================
// skid_buf2 : two-entry push/pop word buffer with occupancy count
// Rev 1.0
// ============================================================================
`default_nettype none

module skid_buf2
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_push,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_pop,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic [1:0]            o_count
);

    logic [DATA_WIDTH-1:0] r_mem [SKID_DEPTH];
    logic                  r_rd_ptr;
    logic                  r_wr_ptr;
    logic [1:0]            r_cnt;
    logic                  w_do_pop;

    assign w_do_pop = i_pop & (r_cnt != 2'd0);
    assign o_data   = r_mem[r_rd_ptr];
    assign o_count  = r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SKID_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_cnt    <= 2'd0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_do_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({i_push, w_do_pop})
                2'b10:   r_cnt <= r_cnt + 2'd1;
                2'b01:   r_cnt <= r_cnt - 2'd1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // The reader's credit scheme must never push into a full buffer.
    a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
        !(i_push && !w_do_pop && (r_cnt == 2'd2)));

endmodule

`default_nettype wire

// File: rtl/fifo_burst_reader.sv
// ============================================================================
// fifo_burst_reader : pops a fixed-length burst from sync_fifo onto a
//                     ready/valid stream, with no-progress timeout abort
// Rev 1.0
// ============================================================================
`default_nettype none

module fifo_burst_reader
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int LEN_WIDTH     = 8,
    parameter int TIMEOUT_LIMIT = DEF_TIMEOUT_LIMIT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [LEN_WIDTH-1:0]  burst_len,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    input  logic                  fifo_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  busy,
    output logic                  done,
    output logic                  timeout_err,
    output logic [LEN_WIDTH-1:0]  word_cnt
);

    localparam int                    c_tmo_w    = $clog2(TIMEOUT_LIMIT + 1);
    localparam logic [LEN_WIDTH-1:0]  c_len_one  = LEN_WIDTH'(1);
    localparam logic [c_tmo_w-1:0]    c_tmo_one  = c_tmo_w'(1);
    localparam logic [c_tmo_w-1:0]    c_tmo_last = c_tmo_w'(TIMEOUT_LIMIT - 1);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [LEN_WIDTH-1:0]  r_len;
    logic [LEN_WIDTH-1:0]  r_issued;
    logic [LEN_WIDTH-1:0]  r_word_cnt;
    logic [c_tmo_w-1:0]    r_tmo_cnt;
    logic                  r_inflight;
    logic                  r_err;

    logic [1:0]            w_skid_cnt;
    logic [DATA_WIDTH-1:0] w_skid_data;
    logic [1:0]            w_used;
    logic                  w_m_valid;
    logic                  w_hs;
    logic                  w_rd_en;
    logic                  w_progress;
    logic                  w_last_word;
    logic                  w_tmo_hit;
    logic                  w_launch;

    skid_buf2 #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (fifo_valid),
        .i_data  (fifo_data),
        .i_pop   (w_hs),
        .o_data  (w_skid_data),
        .o_count (w_skid_cnt)
    );

    assign w_m_valid = (w_skid_cnt != 2'd0);
    assign w_hs      = w_m_valid & m_ready;

    // A word leaving this cycle frees its slot, so it is credited back;
    // that keeps one word per cycle flowing with m_ready held high.
    assign w_used  = w_skid_cnt + {1'b0, r_inflight} - {1'b0, w_hs};
    assign w_rd_en = (r_state == ST_RUN) & ~fifo_empty &
                     (r_issued < r_len) & (w_used < 2'd2);

    assign w_progress  = w_rd_en | w_hs;
    assign w_last_word = w_hs & ((r_word_cnt + c_len_one) == r_len);
    assign w_tmo_hit   = ~w_progress & (r_tmo_cnt == c_tmo_last);
    assign w_launch    = (r_state == ST_IDLE) & start;

    assign fifo_rd_en = w_rd_en;
    assign m_valid    = w_m_valid;
    assign m_data     = w_m_valid ? w_skid_data : '0;
    assign word_cnt   = r_word_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        timeout_err = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = (burst_len == '0) ? ST_FIN : ST_RUN;
                end
            end
            ST_RUN: begin
                busy = 1'b1;
                if (w_last_word) begin
                    w_state_nxt = ST_FIN;
                end else if (w_tmo_hit) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                busy = 1'b1;
                if (!r_inflight && (w_skid_cnt == 2'd0)) begin
                    w_state_nxt = ST_FIN;
                end
            end
            ST_FIN: begin
                done        = 1'b1;
                timeout_err = r_err;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_len      <= '0;
            r_issued   <= '0;
            r_word_cnt <= '0;
            r_tmo_cnt  <= '0;
            r_inflight <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_inflight <= w_rd_en;
            if (w_launch) begin
                r_len      <= burst_len;
                r_issued   <= '0;
                r_word_cnt <= '0;
                r_err      <= 1'b0;
            end else begin
                if (w_rd_en) begin
                    r_issued <= r_issued + c_len_one;
                end
                if (w_hs) begin
                    r_word_cnt <= r_word_cnt + c_len_one;
                end
            end
            // Only RUN is watched; a DRAIN stalled on m_ready waits forever.
            if ((r_state == ST_RUN) && !w_progress) begin
                r_tmo_cnt <= r_tmo_cnt + c_tmo_one;
            end else begin
                r_tmo_cnt <= '0;
            end
            if ((r_state == ST_RUN) && w_tmo_hit) begin
                r_err <= 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fifo_burst_reader.sv
// ============================================================================
// tb_fifo_burst_reader : queue-based FIFO and stream reference for the reader
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_fifo_burst_reader;

    localparam int TMO = 128;

    typedef struct {
        int load;
        int len;
        int rmode;
        int exp_cnt;
        int exp_err;
        int exp_left;
        int gapless;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] burst_len;
    logic       fifo_empty;
    logic       fifo_rd_en;
    logic [7:0] fifo_data;
    logic       fifo_valid;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready;
    logic       busy;
    logic       done;
    logic       timeout_err;
    logic [7:0] word_cnt;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int last_prog = 0;
    int rx_burst = 0;
    int rd_seen = 0;
    int outst = 0;
    int fifo_cnt = 0;
    int rmode = 0;
    int ph = 0;
    bit hold_pend = 1'b0;
    logic [7:0] hold_data = 8'd0;
    logic [7:0] nxt_word = 8'd0;
    logic [7:0] fifo_q[$];
    logic [7:0] src_q[$];
    logic [7:0] exp_q[$];

    fifo_burst_reader #(
        .DATA_WIDTH    (8),
        .LEN_WIDTH     (8),
        .TIMEOUT_LIMIT (TMO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .burst_len   (burst_len),
        .fifo_empty  (fifo_empty),
        .fifo_rd_en  (fifo_rd_en),
        .fifo_data   (fifo_data),
        .fifo_valid  (fifo_valid),
        .m_data      (m_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .busy        (busy),
        .done        (done),
        .timeout_err (timeout_err),
        .word_cnt    (word_cnt)
    );

    always #5 clk = ~clk;

    assign fifo_empty = (fifo_cnt == 0);

    function automatic void chk(input string name, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
        end
    endfunction

    // sync_fifo stand-in: depth 16, one-cycle read latency, fed by src_q
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_q.delete();
            fifo_valid <= 1'b0;
            fifo_data  <= 8'd0;
            fifo_cnt   <= 0;
        end else begin
            fifo_valid <= 1'b0;
            if (fifo_rd_en && fifo_q.size() != 0) begin
                fifo_data  <= fifo_q.pop_front();
                fifo_valid <= 1'b1;
            end
            if (src_q.size() != 0 && fifo_q.size() < 16) begin
                fifo_q.push_back(src_q.pop_front());
            end
            fifo_cnt <= fifo_q.size();
        end
    end

    // stream sink and protocol reference
    always @(posedge clk) begin
        bit acc;
        bit hs;
        cyc++;
        if (!rst_n) begin
            hold_pend = 1'b0;
            outst     = 0;
        end else begin
            if (hold_pend) begin
                chk("hold_valid", int'(m_valid), 1);
                chk("hold_data", int'(m_data), int'(hold_data));
            end
            hold_pend = m_valid && !m_ready;
            hold_data = m_data;
            acc = fifo_rd_en && !fifo_empty;
            hs  = m_valid && m_ready;
            if (fifo_rd_en) begin
                rd_seen++;
                chk("rd_while_empty", int'(fifo_empty), 0);
            end
            if (acc || hs) last_prog = cyc;
            outst = outst + int'(acc) - int'(hs);
            if (acc) chk("outstanding_le_2", int'(outst <= 2), 1);
            if (hs) begin
                rx_burst++;
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_word: got %0d, expected no word", m_data);
                end else begin
                    chk("word_order", int'(m_data), int'(exp_q.pop_front()));
                end
            end
        end
    end

    // m_ready driver: 0 always, 1 pattern 1,0,0,1, 2 random, 3 held low
    initial begin
        m_ready = 1'b1;
        forever begin
            @(negedge clk);
            case (rmode)
                0: m_ready = 1'b1;
                1: begin
                    m_ready = (ph == 0) || (ph == 3);
                    ph = (ph + 1) % 4;
                end
                2: m_ready = ($urandom_range(0, 9) < 7);
                default: m_ready = 1'b0;
            endcase
        end
    end

    task automatic load_words(input int n);
        for (int i = 0; i < n; i++) begin
            src_q.push_back(nxt_word);
            exp_q.push_back(nxt_word);
            nxt_word = nxt_word + 8'd1;
        end
    endtask

    task automatic wait_fill();
        int w;
        w = 0;
        while (src_q.size() != 0 && fifo_cnt < 16 && w < 300) begin
            @(negedge clk);
            w++;
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_rd_en"}, int'(fifo_rd_en), 0);
        chk({tag, "_m_valid"}, int'(m_valid), 0);
        chk({tag, "_m_data"}, int'(m_data), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_terr"}, int'(timeout_err), 0);
        chk({tag, "_word_cnt"}, int'(word_cnt), 0);
    endtask

    task automatic run_burst(input vec_t v);
        int gaps;
        bit seen;
        bit fin;
        load_words(v.load);
        wait_fill();
        @(negedge clk);
        rmode     = v.rmode;
        rx_burst  = 0;
        start     = 1'b1;
        burst_len = 8'(v.len);
        @(negedge clk);
        start     = 1'b0;
        burst_len = 8'($urandom);
        gaps = 0;
        seen = 1'b0;
        fin  = 1'b0;
        for (int c = 0; c < 3000 && !fin; c++) begin
            if (done) begin
                fin = 1'b1;
            end else begin
                // a start outside IDLE must be ignored
                if (c == 3 && v.len >= 10) begin
                    start     = 1'b1;
                    burst_len = 8'd1;
                end else begin
                    start = 1'b0;
                end
                if (v.rmode == 3 && c == 400) rmode = 0;
                if (m_valid) seen = 1'b1;
                else if (seen && rx_burst < v.exp_cnt) gaps++;
                @(negedge clk);
            end
        end
        start = 1'b0;
        chk("done_seen", int'(fin), 1);
        if (fin) begin
            chk("timeout_err", int'(timeout_err), v.exp_err);
            chk("word_cnt", int'(word_cnt), v.exp_cnt);
            chk("words_rx", rx_burst, v.exp_cnt);
            chk("words_left", exp_q.size(), v.exp_left);
            if (v.gapless != 0) chk("gaps", gaps, 0);
            // TMO idle cycles after the last progress, then one DRAIN cycle
            if (v.exp_err != 0 && v.rmode == 0) chk("tmo_latency", cyc - last_prog, TMO + 1);
        end
        @(negedge clk);
        chk("done_one_cycle", int'(done), 0);
        chk("idle_busy", int'(busy), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1);
    end

    initial begin
        vec_t tbl[8];
        vec_t v;
        int w;
        rst_n     = 1'b0;
        start     = 1'b0;
        burst_len = 8'd0;

        tbl[0] = '{28, 28, 0, 28, 0,  0, 1};
        tbl[1] = '{28,  3, 0,  3, 0, 25, 1};
        tbl[2] = '{ 0, 25, 0, 25, 0,  0, 1};
        tbl[3] = '{10, 10, 1, 10, 0,  0, 0};
        tbl[4] = '{ 4,  8, 0,  4, 1,  0, 0};
        tbl[5] = '{ 5,  5, 3,  2, 1,  3, 0};
        tbl[6] = '{ 0,  3, 0,  3, 0,  0, 0};
        tbl[7] = '{ 1,  1, 2,  1, 0,  0, 0};

        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            run_burst(tbl[i]);
        end

        // zero-length burst: done in the cycle after start is sampled, no reads
        rd_seen = 0;
        rmode   = 0;
        @(negedge clk);
        start     = 1'b1;
        burst_len = 8'd0;
        @(negedge clk);
        start = 1'b0;
        chk("len0_done", int'(done), 1);
        chk("len0_terr", int'(timeout_err), 0);
        chk("len0_word_cnt", int'(word_cnt), 0);
        chk("len0_busy", int'(busy), 0);
        @(negedge clk);
        chk("len0_done_drop", int'(done), 0);
        chk("len0_no_reads", rd_seen, 0);

        // reset after 5 of 20 words, then a clean 4-word burst
        load_words(20);
        wait_fill();
        @(negedge clk);
        rmode     = 1;
        rx_burst  = 0;
        start     = 1'b1;
        burst_len = 8'd20;
        @(negedge clk);
        start = 1'b0;
        w = 0;
        while (rx_burst < 5 && w < 500) begin
            @(negedge clk);
            w++;
        end
        chk("mid_rx", rx_burst, 5);
        chk("mid_word_cnt", int'(word_cnt), 5);
        rst_n = 1'b0;
        #1;
        check_reset_vals("async_rst");
        exp_q.delete();
        src_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        v = '{4, 4, 0, 4, 0, 0, 1};
        run_burst(v);

        // randomized bursts against the queue reference
        for (int i = 0; i < 10; i++) begin
            v.len      = $urandom_range(1, 40);
            v.load     = v.len;
            v.rmode    = 2;
            v.exp_cnt  = v.len;
            v.exp_err  = 0;
            v.exp_left = 0;
            v.gapless  = 0;
            run_burst(v);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
